find_best_neighbor: RTL and testbench

Scans the node's neighbour Q-table in shared memory, finds the highest-valued neighbour, and builds the "better neighbour" list that the downstream winner-policy stage uses for exploration. It reads the node's own value (mybest) and the neighbour count, walks every entry, writes qualifying hop IDs and the list length back to memory, and presents mybest/besthop/bestvalue/bestneighborID. It sits directly upstream of the winner-policy stage and shares its 16-bit memory port convention.

---
 rtl/find_best_neighbor.sv | 154 +++++++++++++++
 tb/tb_find_best_neighbor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/find_best_neighbor.sv
// Scans the neighbour Q-table, tracks the highest-valued entry and writes the better-neighbour list.
// Optional FINDBEST_LOOP_GUARD_EN: entries advertising MY_NODE_ID as their best neighbour are kept off the list.
module find_best_neighbor (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start_findBest,
  input  logic [15:0] MY_NODE_ID,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic [15:0] mybest,
  output logic [15:0] besthop,
  output logic [15:0] bestvalue,
  output logic [15:0] bestneighborID,
  output logic [15:0] betterNeighborCount,
  output logic        done_findBest
);

  localparam logic [15:0] MYBEST_ADDR       = 16'h0008;
  localparam logic [15:0] NBR_COUNT_ADDR    = 16'h0006;
  localparam logic [15:0] NBR_TABLE_BASE    = 16'h0600;
  localparam logic [15:0] BETTER_BASE       = 16'h0668;
  localparam logic [15:0] BETTER_COUNT_ADDR = 16'h068C;
  localparam logic [15:0] MAX_NEIGHBORS     = 16'd16;
  localparam logic [15:0] NO_HOP            = 16'd301;

  typedef enum logic [3:0] {
    IDLE, MYB, CNT, HOP, VAL, BID, EVAL, WBET, NEXT, WCNT, WEND, DONE
  } state_t;

  state_t      state;
  logic [4:0]  n;
  logic [4:0]  idx;
  logic [15:0] hop;
  logic [15:0] value;
  logic [15:0] bid;
  logic        list_ok;

`ifdef FINDBEST_LOOP_GUARD_EN
  assign list_ok = (bid != MY_NODE_ID);
`else
  assign list_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state               <= IDLE;
      n                   <= '0;
      idx                 <= '0;
      hop                 <= '0;
      value               <= '0;
      bid                 <= '0;
      address             <= '0;
      data_out            <= '0;
      wr_en               <= 1'b0;
      mybest              <= '0;
      besthop             <= NO_HOP;
      bestvalue           <= '0;
      bestneighborID      <= NO_HOP;
      betterNeighborCount <= '0;
      done_findBest       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_findBest) begin
            done_findBest       <= 1'b0;
            address             <= MYBEST_ADDR;
            besthop             <= NO_HOP;
            bestneighborID      <= NO_HOP;
            bestvalue           <= '0;
            betterNeighborCount <= '0;
            state               <= MYB;
          end
        end
        MYB: begin
          mybest  <= data_in;
          address <= NBR_COUNT_ADDR;
          state   <= CNT;
        end
        CNT: begin
          n   <= (data_in > MAX_NEIGHBORS) ? 5'd16 : data_in[4:0];
          idx <= '0;
          if (data_in == '0) begin
            state <= WCNT;
          end else begin
            address <= NBR_TABLE_BASE;
            state   <= HOP;
          end
        end
        HOP: begin
          hop     <= data_in;
          address <= address + 16'd2;
          state   <= VAL;
        end
        VAL: begin
          value   <= data_in;
          address <= address + 16'd2;
          state   <= BID;
        end
        BID: begin
          bid   <= data_in;
          state <= EVAL;
        end
        EVAL: begin
          // Strict compare keeps the lowest-index entry on ties.
          if (idx == '0 || value > bestvalue) begin
            besthop        <= hop;
            bestvalue      <= value;
            bestneighborID <= bid;
          end
          if (value > mybest && betterNeighborCount < MAX_NEIGHBORS && list_ok) begin
            address  <= BETTER_BASE + (betterNeighborCount << 1);
            data_out <= hop;
            wr_en    <= 1'b1;
            state    <= WBET;
          end else begin
            state <= NEXT;
          end
        end
        WBET: begin
          wr_en               <= 1'b0;
          betterNeighborCount <= betterNeighborCount + 16'd1;
          state               <= NEXT;
        end
        NEXT: begin
          idx <= idx + 5'd1;
          if (idx + 5'd1 == n) begin
            state <= WCNT;
          end else begin
            address <= NBR_TABLE_BASE + 16'(idx + 5'd1) * 16'd6;
            state   <= HOP;
          end
        end
        WCNT: begin
          address  <= BETTER_COUNT_ADDR;
          data_out <= betterNeighborCount;
          wr_en    <= 1'b1;
          state    <= WEND;
        end
        WEND: begin
          wr_en <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done_findBest <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_best_neighbor.sv
// Self-checking bench for find_best_neighbor: directed and random scans against a queue-based reference model.
module tb_find_best_neighbor;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start_findBest;
  logic [15:0] MY_NODE_ID;
  logic [15:0] data_in;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic [15:0] mybest;
  logic [15:0] besthop;
  logic [15:0] bestvalue;
  logic [15:0] bestneighborID;
  logic [15:0] betterNeighborCount;
  logic        done_findBest;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];
  logic [31:0] wq[$];

  find_best_neighbor dut (
    .clock(clock), .nrst(nrst), .start_findBest(start_findBest), .MY_NODE_ID(MY_NODE_ID),
    .data_in(data_in), .address(address), .data_out(data_out), .wr_en(wr_en),
    .mybest(mybest), .besthop(besthop), .bestvalue(bestvalue), .bestneighborID(bestneighborID),
    .betterNeighborCount(betterNeighborCount), .done_findBest(done_findBest)
  );

  always #5 clock = ~clock;

  assign data_in = mem[address];

  always @(posedge clock) begin
    if (wr_en) begin
      mem[address] <= data_out;
      wq.push_back({address, data_out});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int a = 16'h0600; a < 16'h0700; a++) mem[a] = '0;
  endtask

  task automatic set_entry(input int i, input logic [15:0] h, input logic [15:0] v, input logic [15:0] b);
    mem[16'h0600 + 6*i]     = h;
    mem[16'h0600 + 6*i + 2] = v;
    mem[16'h0600 + 6*i + 4] = b;
  endtask

  // Start a scan, wait for done, and compare everything against the reference model.
  task automatic run_scan(input string tag, input bit prev_done);
    int          n, c, limit;
    logic [15:0] mb, bh, bv, bb, h, v, b;
    logic [15:0] lst[$];
    logic [31:0] exp_w[$];
    bit          prev_wr, back2back;

    mb = mem[16'h0008];
    n  = (mem[16'h0006] > 16) ? 16 : int'(mem[16'h0006]);
    bh = 16'd301; bv = '0; bb = 16'd301;
    for (int i = 0; i < n; i++) begin
      h = mem[16'h0600 + 6*i];
      v = mem[16'h0600 + 6*i + 2];
      b = mem[16'h0600 + 6*i + 4];
      if (i == 0 || v > bv) begin bh = h; bv = v; bb = b; end
`ifdef FINDBEST_LOOP_GUARD_EN
      if (v > mb && lst.size() < 16 && b != MY_NODE_ID) lst.push_back(h);
`else
      if (v > mb && lst.size() < 16) lst.push_back(h);
`endif
    end
    foreach (lst[k]) exp_w.push_back({16'(16'h0668 + 2*k), lst[k]});
    exp_w.push_back({16'h068C, 16'(lst.size())});

    @(negedge clock);
    check({tag, ".done_before"}, done_findBest, prev_done);
    wq.delete();
    start_findBest = 1'b1;
    @(posedge clock); #1;
    check({tag, ".done_drop"}, done_findBest, 1'b0);
    prev_wr = wr_en; back2back = 1'b0;
    c = 0; limit = 5 + 5*n + lst.size() + 20;
    while (!done_findBest && c < limit) begin
      @(posedge clock); #1;
      c++;
      if (c == 1) start_findBest = 1'b0;
      if (wr_en && prev_wr) back2back = 1'b1;
      prev_wr = wr_en;
    end
    check({tag, ".cycles"}, c, 5 + 5*n + lst.size());
    check({tag, ".mybest"}, mybest, mb);
    check({tag, ".besthop"}, besthop, bh);
    check({tag, ".bestvalue"}, bestvalue, bv);
    check({tag, ".bestnbr"}, bestneighborID, bb);
    check({tag, ".count"}, betterNeighborCount, 16'(lst.size()));
    check({tag, ".nwrites"}, wq.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wq.size(); k++)
      check($sformatf("%s.write%0d", tag, k), wq[k], exp_w[k]);
    check({tag, ".wr_gap"}, back2back, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".wr_en"}, wr_en, 1'b0);
    check({tag, ".done"}, done_findBest, 1'b0);
    check({tag, ".address"}, address, 16'h0000);
    check({tag, ".data_out"}, data_out, 16'h0000);
    check({tag, ".mybest"}, mybest, 16'h0000);
    check({tag, ".bestvalue"}, bestvalue, 16'h0000);
    check({tag, ".count"}, betterNeighborCount, 16'h0000);
    check({tag, ".besthop"}, besthop, 16'd301);
    check({tag, ".bestnbr"}, bestneighborID, 16'd301);
  endtask

  initial begin
    logic [15:0] mbr;
    int          nr, waited;

    for (int a = 0; a < 65536; a++) mem[a] = '0;
    nrst = 1'b0; start_findBest = 1'b0; MY_NODE_ID = 16'd3;
    repeat (3) @(posedge clock);
    #1 check_reset_values("reset");
    @(negedge clock) nrst = 1'b1;

    // n = 0
    clear_table(); mem[16'h0008] = 16'h0100; mem[16'h0006] = 16'd0;
    run_scan("n0", 1'b0);

    // n = 3 with a tie on the best value
    clear_table(); mem[16'h0008] = 16'h0100; mem[16'h0006] = 16'd3;
    set_entry(0, 16'd5, 16'h0080, 16'd11);
    set_entry(1, 16'd7, 16'h0200, 16'd12);
    set_entry(2, 16'd9, 16'h0200, 16'd13);
    run_scan("n3", 1'b1);
    check("n3.besthop_lit", besthop, 16'd7);

    // n = 20 clamps to 16
    clear_table(); mem[16'h0008] = 16'h0010; mem[16'h0006] = 16'd20;
    for (int i = 0; i < 20; i++) set_entry(i, 16'(100 + i), 16'(16'h0100 + i), 16'd50);
    run_scan("n20", 1'b1);
    check("n20.count_lit", betterNeighborCount, 16'd16);

    // Loop guard: entry advertising MY_NODE_ID
    clear_table(); mem[16'h0008] = 16'h0100; mem[16'h0006] = 16'd2;
    set_entry(0, 16'd20, 16'h0300, 16'd3);
    set_entry(1, 16'd21, 16'h0180, 16'd4);
    run_scan("guard", 1'b1);

    // Reset during a list write, then a clean scan
    clear_table(); mem[16'h0008] = 16'h0100; mem[16'h0006] = 16'd3;
    set_entry(0, 16'd5, 16'h0080, 16'd11);
    set_entry(1, 16'd7, 16'h0200, 16'd12);
    set_entry(2, 16'd9, 16'h0200, 16'd13);
    @(negedge clock) start_findBest = 1'b1;
    @(posedge clock); #1 start_findBest = 1'b0;
    waited = 0;
    while (!wr_en && waited < 40) begin @(posedge clock); #1 waited++; end
    check("midrst.reached_write", wr_en, 1'b1);
    #2 nrst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clock) nrst = 1'b1;
    run_scan("after_rst", 1'b0);

    // Random scans; values clustered around mybest to hit strict-compare edges
    for (int t = 0; t < 10; t++) begin
      clear_table();
      mbr = 16'($urandom_range(1, 16'hFFFE));
      nr  = $urandom_range(0, 20);
      MY_NODE_ID = 16'($urandom_range(0, 7));
      mem[16'h0008] = mbr; mem[16'h0006] = 16'(nr);
      for (int i = 0; i < nr; i++) begin
        logic [15:0] v;
        case ($urandom_range(0, 3))
          0: v = mbr - 16'd1;
          1: v = mbr;
          2: v = mbr + 16'd1;
          default: v = 16'($urandom);
        endcase
        set_entry(i, 16'($urandom_range(0, 300)), v, 16'($urandom_range(0, 7)));
      end
      run_scan($sformatf("rand%0d", t), 1'b1);
    end

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
